tpx3_packet_assembler: RTL and testbench

Sits directly downstream of the per-link receiver FIFO. It pops 25-bit half-packet words (bit 24 = 1 marks the upper half, bit 24 = 0 the lower half) and pairs them into 48-bit Timepix3 packets. Each packet is presented on a valid/ready output toward the readout mux. Words arriving out of order, and upper halves left stranded, are dropped and counted.

---
 rtl/tpx3_packet_assembler.sv | 147 ++++++++++++++
 tb/tb_tpx3_packet_assembler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tpx3_packet_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tpx3_packet_assembler
// Purpose  : Pops 25-bit half-packet words from a first-word-fall-through
//            receiver FIFO (bit 24 = 1 upper half, 0 lower half) and pairs
//            them into 48-bit Timepix3 packets on a valid/ready output.
//            Out-of-order halves and timed-out upper halves are dropped and
//            counted in a saturating error counter.
// Ports    : BUS_CLK, RESET (sync, active-high)
//            enable                 - pop permission
//            fifo_data/fifo_empty   - FIFO head word / empty flag
//            fifo_read              - pop strobe (combinational)
//            packet_data/valid/ready- output packet handshake
//            order_err_cnt          - saturating dropped-half count
//            packet_cnt             - wrapping accepted-packet count
//            state_busy             - an upper half is being held
// Revision : 1.0 - initial release
// ============================================================================
module tpx3_packet_assembler #(
  parameter int TIMEOUT = 255
) (
  input  logic        BUS_CLK,
  input  logic        RESET,
  input  logic        enable,
  input  logic [24:0] fifo_data,
  input  logic        fifo_empty,
  output logic        fifo_read,
  output logic [47:0] packet_data,
  output logic        packet_valid,
  input  logic        packet_ready,
  output logic [7:0]  order_err_cnt,
  output logic [15:0] packet_cnt,
  output logic        state_busy
);

  // The counter only ever needs to hold 0..TIMEOUT-1: the timeout fires on
  // the idle cycle seen while it already holds TIMEOUT-1.
  localparam int             c_TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_TW-1:0] c_TLIM = c_TW'(TIMEOUT - 1);
  localparam logic [c_TW-1:0] c_TONE = c_TW'(1);

  typedef enum logic [0:0] {
    S_WAIT_HIGH = 1'b0,
    S_WAIT_LOW  = 1'b1
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [23:0]     r_upper, w_upper_nxt;
  logic [c_TW-1:0] r_tmo, w_tmo_nxt;
  logic [47:0]     r_data;
  logic            r_valid;
  logic [7:0]      r_err;
  logic [15:0]     r_cnt;
  logic            w_load;
  logic            w_err;
  logic            w_out_free;
  logic            w_tmo_hit;

  assign w_out_free = !r_valid || packet_ready;
  assign w_tmo_hit  = (TIMEOUT != 0) && (r_tmo == c_TLIM);

  always_comb begin
    w_state_nxt = r_state;
    w_upper_nxt = r_upper;
    w_tmo_nxt   = r_tmo;
    w_load      = 1'b0;
    w_err       = 1'b0;
    fifo_read   = 1'b0;
    case (r_state)
      S_WAIT_HIGH: begin
        fifo_read = !RESET && enable && !fifo_empty;
        if (fifo_read) begin
          if (fifo_data[24]) begin
            w_upper_nxt = fifo_data[23:0];
            w_state_nxt = S_WAIT_LOW;
            w_tmo_nxt   = '0;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      S_WAIT_LOW: begin
        // A new upper half may always be popped; a lower half only when the
        // output register can take the completed packet.
        fifo_read = !RESET && enable && !fifo_empty && (fifo_data[24] || w_out_free);
        if (fifo_read) begin
          if (!fifo_data[24]) begin
            w_load      = 1'b1;
            w_state_nxt = S_WAIT_HIGH;
          end else begin
            w_err       = 1'b1;
            w_upper_nxt = fifo_data[23:0];
            w_tmo_nxt   = '0;
          end
        end else if (enable && !fifo_empty && !w_out_free) begin
          // Lower half waiting on a blocked output: everything frozen.
          w_tmo_nxt = r_tmo;
        end else if (w_tmo_hit) begin
          w_err       = 1'b1;
          w_state_nxt = S_WAIT_HIGH;
          w_tmo_nxt   = '0;
        end else begin
          w_tmo_nxt = r_tmo + c_TONE;
        end
      end
      default: begin
        w_state_nxt = S_WAIT_HIGH;
      end
    endcase
  end

  always_ff @(posedge BUS_CLK) begin
    if (RESET) begin
      r_state <= S_WAIT_HIGH;
      r_upper <= '0;
      r_tmo   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_err   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_upper <= w_upper_nxt;
      r_tmo   <= w_tmo_nxt;
      if (w_load) begin
        r_valid <= 1'b1;
        r_data  <= {r_upper, fifo_data[23:0]};
      end else if (packet_ready) begin
        r_valid <= 1'b0;
      end
      if (r_valid && packet_ready) begin
        r_cnt <= r_cnt + 16'd1;
      end
      if (w_err && (r_err != 8'hFF)) begin
        r_err <= r_err + 8'd1;
      end
    end
  end

  assign packet_data   = r_data;
  assign packet_valid  = r_valid;
  assign order_err_cnt = r_err;
  assign packet_cnt    = r_cnt;
  assign state_busy    = (r_state == S_WAIT_LOW);

endmodule
`default_nettype wire

// File: tb/tb_tpx3_packet_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_tpx3_packet_assembler
// Purpose  : Self-checking bench for tpx3_packet_assembler. A queue models
//            the receiver FIFO; a behavioural model of the pairing rules
//            predicts every output each cycle, and literal expectations pin
//            the directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tpx3_packet_assembler;

  localparam int TMO = 8;

  logic        BUS_CLK = 1'b0;
  logic        RESET;
  logic        enable;
  logic [24:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_read;
  logic [47:0] packet_data;
  logic        packet_valid;
  logic        packet_ready;
  logic [7:0]  order_err_cnt;
  logic [15:0] packet_cnt;
  logic        state_busy;

  always #5 BUS_CLK = ~BUS_CLK;

  tpx3_packet_assembler #(.TIMEOUT(TMO)) dut (
    .BUS_CLK      (BUS_CLK),
    .RESET        (RESET),
    .enable       (enable),
    .fifo_data    (fifo_data),
    .fifo_empty   (fifo_empty),
    .fifo_read    (fifo_read),
    .packet_data  (packet_data),
    .packet_valid (packet_valid),
    .packet_ready (packet_ready),
    .order_err_cnt(order_err_cnt),
    .packet_cnt   (packet_cnt),
    .state_busy   (state_busy)
  );

  int total = 0;
  int bad   = 0;

  // model state: "holding an upper half", how long it has waited, the
  // output slot, and the two counters
  bit          m_known = 0;
  bit          m_busy;
  logic [23:0] m_upper;
  int          m_wait;
  bit          m_valid;
  logic [47:0] m_data;
  int          m_err;
  int          m_cnt;

  logic [24:0] fq[$];
  logic [47:0] acc_q[$];
  logic [47:0] exp_pk[$];
  int          rd_count;
  bit          s_rst, s_en, s_rdy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    bit          empty, exp_rd, acc, err_inc, load;
    logic [24:0] head;
    logic [47:0] ld;
    empty = (fq.size() == 0);
    head  = empty ? 25'($urandom) : fq[0];
    RESET = s_rst; enable = s_en; packet_ready = s_rdy;
    fifo_empty = empty; fifo_data = head;
    #1;
    exp_rd = !s_rst && s_en && !empty && (!m_busy || head[24] || !m_valid || s_rdy);
    chk("fifo_read", fifo_read, exp_rd);
    if (m_known) begin
      chk("packet_valid", packet_valid, m_valid);
      chk("packet_data", packet_data, m_data);
      chk("order_err_cnt", order_err_cnt, m_err);
      chk("packet_cnt", packet_cnt, m_cnt);
      chk("state_busy", state_busy, m_busy);
    end
    if (fifo_read) begin
      rd_count++;
      if (!empty) void'(fq.pop_front());
    end
    if (!s_rst && packet_valid && s_rdy) acc_q.push_back(packet_data);
    // advance the model across the coming edge
    if (s_rst) begin
      m_known = 1; m_busy = 0; m_upper = '0; m_wait = 0;
      m_valid = 0; m_data = '0; m_err = 0; m_cnt = 0;
    end else begin
      acc = m_valid && s_rdy; load = 0; err_inc = 0; ld = '0;
      if (!m_busy) begin
        if (exp_rd) begin
          if (head[24]) begin m_upper = head[23:0]; m_busy = 1; m_wait = 0; end
          else err_inc = 1;
        end
      end else if (exp_rd) begin
        if (!head[24]) begin load = 1; ld = {m_upper, head[23:0]}; m_busy = 0; end
        else begin err_inc = 1; m_upper = head[23:0]; m_wait = 0; end
      end else if (s_en && !empty && m_valid && !s_rdy) begin
        // lower half blocked by a full output: nothing moves
      end else begin
        m_wait++;
        if (TMO != 0 && m_wait == TMO) begin m_busy = 0; err_inc = 1; end
      end
      if (load) begin m_valid = 1; m_data = ld; end
      else if (acc) m_valid = 0;
      if (acc) m_cnt = (m_cnt + 1) & 16'hFFFF;
      if (err_inc && m_err < 255) m_err++;
    end
    @(posedge BUS_CLK);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int base;
    bit next_hi;
    logic [23:0] a, b;
    s_rst = 1; s_en = 1; s_rdy = 1;
    run(2);
    s_rst = 0;
    chk("reset_cnt", packet_cnt, 0);
    chk("reset_valid", packet_valid, 0);
    chk("reset_busy", state_busy, 0);

    // single packet
    fq.push_back(25'h1ABCDEF); fq.push_back(25'h0123456);
    run(4);
    chk("first_pkt", acc_q[0], 48'hABCDEF123456);
    chk("first_cnt", packet_cnt, 1);
    chk("first_err", order_err_cnt, 0);

    // 100 back-to-back pairs
    base = acc_q.size();
    for (int i = 0; i < 100; i++) begin
      a = 24'($urandom); b = 24'($urandom);
      fq.push_back({1'b1, a}); fq.push_back({1'b0, b});
      exp_pk.push_back({a, b});
    end
    rd_count = 0;
    run(200);
    chk("stream_duty", rd_count, 200);
    run(3);
    chk("stream_cnt", packet_cnt, 101);
    chk("stream_num", acc_q.size() - base, 100);
    for (int i = 0; i < 100; i++) chk("stream_order", acc_q[base + i], exp_pk[i]);

    // orphan lower and replaced upper
    fq.push_back(25'h0000011); fq.push_back(25'h1AAAAAA);
    fq.push_back(25'h1BBBBBB); fq.push_back(25'h0CCCCCC);
    run(8);
    chk("order_pkt", acc_q[acc_q.size() - 1], 48'hBBBBBBCCCCCC);
    chk("order_err", order_err_cnt, 2);
    chk("order_cnt", packet_cnt, 102);

    // backpressure
    fq.push_back(25'h1000001); fq.push_back(25'h0000002);
    fq.push_back(25'h1000003); fq.push_back(25'h0000004);
    s_rdy = 0; rd_count = 0;
    run(20);
    chk("bp_reads", rd_count, 3);
    chk("bp_hold", packet_data, 48'h000001000002);
    chk("bp_busy", state_busy, 1);
    base = acc_q.size();
    s_rdy = 1;
    run(4);
    chk("bp_num", acc_q.size() - base, 2);
    chk("bp_first", acc_q[base], 48'h000001000002);
    chk("bp_second", acc_q[base + 1], 48'h000003000004);

    // timeout of a stranded upper half
    base = acc_q.size();
    fq.push_back(25'h1123456);
    run(8);
    chk("tmo_pre_busy", state_busy, 1);
    run(1);
    chk("tmo_busy", state_busy, 0);
    chk("tmo_err", order_err_cnt, 3);
    run(3);
    chk("tmo_nopkt", acc_q.size() - base, 0);

    // randomized traffic
    next_hi = 1;
    for (int c = 0; c < 3000; c++) begin
      s_en  = ($urandom % 8) != 0;
      s_rdy = ($urandom % 4) != 0;
      if (($urandom % 2) == 0 && fq.size() < 16) begin
        if (($urandom % 10) < 8) begin
          fq.push_back({next_hi, 24'($urandom)});
          next_hi = !next_hi;
        end else begin
          fq.push_back(25'($urandom));
        end
      end
      step();
    end
    s_en = 1; s_rdy = 1;
    run(40);

    // saturation
    s_rst = 1; run(1); s_rst = 0;
    for (int i = 0; i < 300; i++) fq.push_back({1'b0, 24'($urandom)});
    run(310);
    chk("sat_err", order_err_cnt, 8'hFF);

    // reset mid-packet with a pending packet
    s_rdy = 0;
    fq.push_back(25'h10AAAAA); fq.push_back(25'h00BBBBB);
    run(3);
    fq.push_back(25'h10CCCCC);
    run(2);
    chk("mid_busy", state_busy, 1);
    chk("mid_valid", packet_valid, 1);
    fq.push_back(25'h00DDDDD);
    s_rst = 1;
    run(1);
    s_rst = 0;
    chk("rst_valid", packet_valid, 0);
    chk("rst_busy", state_busy, 0);
    chk("rst_err", order_err_cnt, 0);
    chk("rst_cnt", packet_cnt, 0);
    chk("rst_data", packet_data, 48'h0);
    s_rdy = 1;
    run(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
